// File: rtl/sha_sched.sv
// Round-robin scheduler sharing one sha_block padder and one compression core among NR requesters.
// Ports: clk, rst, Req, Grant, Done, Busy, Pad_Enable/Func/Ready, Core_Start/First/Ready, Error.
// Optional watchdog: define SHA_SCHED_TIMEOUT_EN (limit TMO cycles in PAD/HASH).
module sha_sched #(
  parameter int NR   = 4,
  parameter int NBLK = 2,
  parameter int TMO  = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NR-1:0] Req,
  output logic [NR-1:0] Grant,
  output logic [NR-1:0] Done,
  output logic          Busy,
  output logic          Pad_Enable,
  output logic          Pad_Func,
  input  logic          Pad_Ready,
  output logic          Core_Start,
  output logic          Core_First,
  input  logic          Core_Ready,
  output logic          Error
);

  localparam int RW = (NR > 1) ? $clog2(NR) : 1;

  typedef enum logic [2:0] {
    IDLE, ARB, PAD, HASH, NEXT, FIN
  } state_t;

  state_t        state, state_n;
  logic [NR-1:0] grant, grant_n;
  logic [RW-1:0] rr, rr_n;
  logic [7:0]    blk, blk_n;
  logic          first;
  logic          pick_ok;
  logic [RW-1:0] pick;
  logic          tmo_hit;

  // First requester at or after rr, wrapping; descending scan so the
  // closest candidate overwrites the rest.
  always_comb begin
    int idx;
    idx     = 0;
    pick_ok = 1'b0;
    pick    = '0;
    for (int i = NR - 1; i >= 0; i--) begin
      idx = (int'(rr) + i) % NR;
      if (Req[idx]) begin
        pick_ok = 1'b1;
        pick    = RW'(idx);
      end
    end
  end

`ifdef SHA_SCHED_TIMEOUT_EN
  logic [15:0] cnt;
  logic        wait_st;

  assign wait_st = (state == PAD  && !Pad_Ready) ||
                   (state == HASH && !Core_Ready);
  assign tmo_hit = wait_st && (cnt == 16'(TMO));

  // Restarts on every PAD/HASH entry, counts cycles spent waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_n != state) begin
      cnt <= '0;
    end else if (wait_st) begin
      cnt <= cnt + 16'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    grant_n = grant;
    rr_n    = rr;
    blk_n   = blk;
    unique case (state)
      IDLE: begin
        if (|Req) state_n = ARB;
      end
      ARB: begin
        if (pick_ok) begin
          grant_n = {{(NR-1){1'b0}}, 1'b1} << pick;
          rr_n    = (int'(pick) == NR - 1) ? '0 : pick + RW'(1);
          blk_n   = '0;
          state_n = PAD;
        end else begin
          state_n = IDLE;
        end
      end
      PAD: begin
        if (Pad_Ready) begin
          state_n = HASH;
        end else if (tmo_hit) begin
          grant_n = '0;
          state_n = IDLE;
        end
      end
      HASH: begin
        if (Core_Ready) begin
          blk_n   = blk + 8'd1;
          state_n = NEXT;
        end else if (tmo_hit) begin
          grant_n = '0;
          state_n = IDLE;
        end
      end
      NEXT: begin
        state_n = (blk == 8'(NBLK)) ? FIN : PAD;
      end
      FIN: begin
        grant_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      rr    <= '0;
      blk   <= '0;
      first <= 1'b0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      rr    <= rr_n;
      blk   <= blk_n;
      // Marks the entry cycle of PAD/HASH for the one-shot pulses.
      first <= (state_n != state) &&
               (state_n == PAD || state_n == HASH);
    end
  end

  assign Grant      = grant;
  assign Busy       = (state != IDLE);
  assign Pad_Enable = (state == PAD) && first;
  assign Pad_Func   = (state == PAD) && (blk != 8'd0);
  assign Core_Start = (state == HASH) && first;
  assign Core_First = Core_Start && (blk == 8'd0);
  assign Done       = (state == FIN) ? grant : '0;
  assign Error      = tmo_hit;

endmodule
